prog_loader: RTL and testbench

- Host-side program loader sitting directly upstream of `cpu`.
- Accepts a byte stream on a valid/ready handshake and buffers a complete program of up to 16 instruction words.
- Replays the program into the CPU's interrupt / io_inst / io_din load port with the load sequencing the CPU expects, then releases the CPU to run.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_buf.sv | 29 ++
 rtl/prog_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader and its buffer.
// Mirrors the CPU's instruction/data widths and the LD_INS load opcode.
package prog_loader_pkg;

    localparam int DEF_BIT_INST = 16;
    localparam int DEF_BIT_DATA = 16;
    localparam int DEF_SZB_INS  = 4;

    // Load opcode occupying the top nibble of io_inst during a load beat.
    localparam logic [3:0] LD_INS = 4'hC;

    typedef enum logic [2:0] {
        PL_IDLE,
        PL_RX_HI,
        PL_RX_LO,
        PL_RX_CK,
        PL_ISSUE,
        PL_FINAL,
        PL_RELEASE
    } pl_state_t;

endpackage

// File: rtl/prog_loader_buf.sv
// Program word buffer: 2**AW x DW register file, one synchronous write port
// and one asynchronous read port.
module prog_buf #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    generate
        for (genvar gi = 0; gi < 2**AW; gi++) begin : g_row
            always_ff @(posedge clk) begin
                if (we && (wr_addr == AW'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: buffers a byte-framed program and replays it into the CPU load port.
// Build option PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int BIT_INST    = DEF_BIT_INST,
    parameter int BIT_DATA    = DEF_BIT_DATA,
    parameter int SZB_INS     = DEF_SZB_INS,
    parameter int BEAT_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                interrupt,
    output logic [BIT_INST-1:0] io_inst,
    output logic [BIT_DATA-1:0] io_din,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int AW = SZB_INS;
    localparam logic [AW:0]   ONE_W    = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [3:0]    CYC_LAST = 4'(BEAT_CYCLES - 1);
    localparam logic [8:0]    DEPTH9   = 9'(2**AW);

    pl_state_t state_reg, state_next;
    logic [AW:0]          n_reg, n_next;
    logic [AW:0]          wr_ptr_reg, wr_ptr_next;
    logic [AW:0]          beat_reg, beat_next;
    logic [3:0]           cyc_reg, cyc_next;
    logic [7:0]           hi_reg, hi_next;
    logic                 rx_ready_reg, rx_ready_next;
    logic                 interrupt_reg, interrupt_next;
    logic [BIT_INST-1:0]  io_inst_reg, io_inst_next;
    logic [BIT_DATA-1:0]  io_din_reg, io_din_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]           ck_reg, ck_next;
`endif

    logic                 take;
    logic                 buf_we;
    logic [AW-1:0]        rd_addr;
    logic [BIT_DATA-1:0]  rd_data;

    assign take = rx_valid && rx_ready_reg;

    prog_buf #(.AW(AW), .DW(BIT_DATA)) u_buf (
        .clk     (clock),
        .we      (buf_we),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data ({hi_reg, rx_data}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= PL_IDLE;
            n_reg         <= '0;
            wr_ptr_reg    <= '0;
            beat_reg      <= '0;
            cyc_reg       <= '0;
            hi_reg        <= '0;
            rx_ready_reg  <= 1'b1;
            interrupt_reg <= 1'b0;
            io_inst_reg   <= '0;
            io_din_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            ck_reg        <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            n_reg         <= n_next;
            wr_ptr_reg    <= wr_ptr_next;
            beat_reg      <= beat_next;
            cyc_reg       <= cyc_next;
            hi_reg        <= hi_next;
            rx_ready_reg  <= rx_ready_next;
            interrupt_reg <= interrupt_next;
            io_inst_reg   <= io_inst_next;
            io_din_reg    <= io_din_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            ck_reg        <= ck_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        n_next      = n_reg;
        wr_ptr_next = wr_ptr_reg;
        beat_next   = beat_reg;
        cyc_next    = cyc_reg;
        hi_next     = hi_reg;
        err_next    = 1'b0;
        buf_we      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        ck_next     = ck_reg;
`endif

        case (state_reg)
            PL_IDLE: begin
                if (take) begin
                    if ((rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH9)) begin
                        err_next = 1'b1;
                    end else begin
                        n_next      = rx_data[AW:0];
                        wr_ptr_next = '0;
                        state_next  = PL_RX_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
                        ck_next     = rx_data;
`endif
                    end
                end
            end
            PL_RX_HI: begin
                if (take) begin
                    hi_next    = rx_data;
                    state_next = PL_RX_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    ck_next    = ck_reg ^ rx_data;
`endif
                end
            end
            PL_RX_LO: begin
                if (take) begin
                    buf_we      = 1'b1;
                    wr_ptr_next = wr_ptr_reg + ONE_W;
`ifdef PROG_LOADER_CHECKSUM_EN
                    ck_next     = ck_reg ^ hi_reg ^ rx_data;
`endif
                    if (wr_ptr_reg == n_reg - ONE_W) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_next = PL_RX_CK;
`else
                        state_next = PL_ISSUE;
                        beat_next  = '0;
                        cyc_next   = '0;
`endif
                    end else begin
                        state_next = PL_RX_HI;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            PL_RX_CK: begin
                if (take) begin
                    if (rx_data == ck_reg) begin
                        state_next = PL_ISSUE;
                        beat_next  = '0;
                        cyc_next   = '0;
                    end else begin
                        err_next   = 1'b1;
                        state_next = PL_IDLE;
                    end
                end
            end
`endif
            PL_ISSUE: begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_next = '0;
                    if (beat_reg == n_reg - ONE_W) begin
                        state_next = PL_FINAL;
                    end else begin
                        beat_next = beat_reg + ONE_W;
                    end
                end else begin
                    cyc_next = cyc_reg + 4'd1;
                end
            end
            PL_FINAL: begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_next   = '0;
                    state_next = PL_RELEASE;
                end else begin
                    cyc_next = cyc_reg + 4'd1;
                end
            end
            PL_RELEASE: state_next = PL_IDLE;
            default:    state_next = PL_IDLE;
        endcase

        // Outputs are decoded from the upcoming state so they register in step with it.
        // Data trails the address by one beat: beat k carries buf[k-1].
        rd_addr        = (state_next == PL_ISSUE) ? (beat_next[AW-1:0] - ONE_A)
                                                  : (n_reg[AW-1:0] - ONE_A);
        interrupt_next = (state_next == PL_ISSUE) || (state_next == PL_FINAL);
        io_inst_next   = '0;
        io_din_next    = '0;
        if (state_next == PL_ISSUE) begin
            io_inst_next = {LD_INS, beat_next[AW-1:0], 8'h00};
            if (beat_next != '0) begin
                io_din_next = rd_data;
            end
        end else if (state_next == PL_FINAL) begin
            io_inst_next = '1;
            io_din_next  = rd_data;
        end
        done_next     = (state_next == PL_RELEASE);
        busy_next     = (state_next != PL_IDLE) && (state_next != PL_RELEASE);
        rx_ready_next = (state_next == PL_IDLE) || (state_next == PL_RX_HI) ||
                        (state_next == PL_RX_LO) || (state_next == PL_RX_CK);
    end

    assign rx_ready  = rx_ready_reg;
    assign interrupt = interrupt_reg;
    assign io_inst   = io_inst_reg;
    assign io_din    = io_din_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (BEAT_CYCLES=1 and 3) share one byte stream.
// Frames gain a trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        rdy1, int1, busy1, done1, err1;
    logic [15:0] inst1, din1;
    logic        rdy3, int3, busy3, done3, err3;
    logic [15:0] inst3, din3;

    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    prog_loader #(.BEAT_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy1), .interrupt(int1), .io_inst(inst1), .io_din(din1),
        .busy(busy1), .done(done1), .err(err1)
    );

    prog_loader #(.BEAT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy3), .interrupt(int3), .io_inst(inst3), .io_din(din3),
        .busy(busy3), .done(done3), .err(err3)
    );

    // Cumulative activity monitors, sampled on the falling edge.
    int          icnt1 = 0;
    int          icnt3 = 0;
    int          addr0_cnt3 = 0;
    logic [15:0] last_din3 = 16'h0;
    logic [15:0] last_inst3 = 16'h0;
    logic [15:0] seen3 = 16'h0;

    always @(negedge clock) begin
        if (int1) icnt1 <= icnt1 + 1;
        if (int3) begin
            icnt3      <= icnt3 + 1;
            last_din3  <= din3;
            last_inst3 <= inst3;
            if (inst3[15:12] == 4'hC) begin
                seen3[inst3[11:8]] <= 1'b1;
                if (inst3[11:8] == 4'h0) addr0_cnt3 <= addr0_cnt3 + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    logic [15:0] words [16];

    task automatic send_frame(input int n, input bit ck_override, input logic [7:0] ck_value);
        logic [7:0] ck;
        ck = 8'(n);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8]);
            send_byte(words[i][7:0]);
            ck = ck ^ words[i][15:8] ^ words[i][7:0];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(ck_override ? ck_value : ck);
`else
        if (ck_override && (ck == ck_value)) begin
            ck = 8'h00;
        end
`endif
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy1 && !busy3 && rdy1 && rdy3 && !int1 && !int3) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    int c1, c3, z3;

    initial begin
        // Reset during idle
        tick();
        tick();
        check("rst_ready1", {31'd0, rdy1}, 32'd1);
        check("rst_int1", {31'd0, int1}, 32'd0);
        check("rst_outs1", {inst1, din1}, 32'h0);
        check("rst_flags1", {29'd0, busy1, done1, err1}, 32'd0);
        check("rst_ready3", {31'd0, rdy3}, 32'd1);
        reset = 1'b0;
        tick();

        // N=2, BEAT_CYCLES=1 sequence
        c1 = icnt1;
        c3 = icnt3;
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("hdr_busy1", {31'd0, busy1}, 32'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD);
`endif
        check("n2_b0", {15'd0, int1, inst1}, 32'h0001_C000);
        check("n2_b0_din", {16'd0, din1}, 32'h0000);
        check("n2_b0_rdy", {31'd0, rdy1}, 32'd0);
        tick();
        check("n2_b1", {15'd0, int1, inst1}, 32'h0001_C100);
        check("n2_b1_din", {16'd0, din1}, 32'h1234);
        tick();
        check("n2_fin", {15'd0, int1, inst1}, 32'h0001_FFFF);
        check("n2_fin_din", {16'd0, din1}, 32'hABCD);
        tick();
        check("n2_rel", {28'd0, int1, done1, busy1, rdy1}, 32'b0100);
        check("n2_rel_outs", {inst1, din1}, 32'h0);
        tick();
        check("n2_after", {28'd0, int1, done1, busy1, rdy1}, 32'b0001);
        wait_idle("n2");
        check("n2_icnt1", 32'(icnt1 - c1), 32'd3);
        check("n2_icnt3", 32'(icnt3 - c3), 32'd9);

        // N=16, words 0..15
        c1 = icnt1;
        c3 = icnt3;
        z3 = addr0_cnt3;
        for (int i = 0; i < 16; i++) words[i] = 16'(i);
        send_frame(16, 1'b0, 8'h00);
        wait_idle("n16");
        check("n16_icnt3", 32'(icnt3 - c3), 32'd51);
        check("n16_icnt1", 32'(icnt1 - c1), 32'd17);
        check("n16_last_din3", {16'd0, last_din3}, 32'h000F);
        check("n16_last_inst3", {16'd0, last_inst3}, 32'hFFFF);
        check("n16_addr15", {31'd0, seen3[15]}, 32'd1);
        check("n16_addr0_once", 32'(addr0_cnt3 - z3), 32'd3);

        // Illegal counts 0x00 and 0x11
        c1 = icnt1;
        c3 = icnt3;
        send_byte(8'h00);
        check("n0_err", {30'd0, err1, err3}, 32'b11);
        check("n0_busy", {30'd0, busy1, busy3}, 32'b00);
        tick();
        check("n0_err_pulse", {30'd0, err1, err3}, 32'b00);
        send_byte(8'h11);
        check("n17_err", {30'd0, err1, err3}, 32'b11);
        check("n17_busy", {30'd0, busy1, busy3}, 32'b00);
        check("n17_ready", {30'd0, rdy1, rdy3}, 32'b11);
        tick();
        tick();
        check("bad_no_int", 32'((icnt1 - c1) + (icnt3 - c3)), 32'd0);

        // Reset two beats into ISSUE of an N=4 frame
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        send_frame(4, 1'b0, 8'h00);
        tick();
        tick();
        check("n4_b2", {15'd0, int1, inst1}, 32'h0001_C200);
        check("n4_b2_din", {16'd0, din1}, 32'h2222);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_int", {30'd0, int1, int3}, 32'b00);
        check("rst_mid_state", {28'd0, busy1, busy3, rdy1, rdy3}, 32'b0011);
        words[0] = 16'h5A5A;
        send_frame(1, 1'b0, 8'h00);
        check("n1_b0", {15'd0, int1, inst1}, 32'h0001_C000);
        check("n1_b0_din", {16'd0, din1}, 32'h0000);
        tick();
        check("n1_fin", {15'd0, int1, inst1}, 32'h0001_FFFF);
        check("n1_fin_din", {16'd0, din1}, 32'h5A5A);
        tick();
        check("n1_done", {30'd0, done1, int1}, 32'b10);
        wait_idle("n1");

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum accepted (0x27) then rejected (0x00)
        words[0] = 16'h1234;
        send_frame(1, 1'b1, 8'h27);
        check("ck_ok_b0", {15'd0, int1, inst1}, 32'h0001_C000);
        tick();
        check("ck_ok_fin_din", {16'd0, din1}, 32'h1234);
        wait_idle("ck_ok");
        c1 = icnt1;
        c3 = icnt3;
        send_frame(1, 1'b1, 8'h00);
        check("ck_bad_err", {30'd0, err1, err3}, 32'b11);
        check("ck_bad_busy", {30'd0, busy1, busy3}, 32'b00);
        tick();
        tick();
        check("ck_bad_no_int", 32'((icnt1 - c1) + (icnt3 - c3)), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
